// File: rtl/gpio_apb_port_pkg.sv
// Shared constants for the 8-bit APB GPIO port: widths, register selects
// and reset values.
package gpio_apb_port_pkg;
  localparam int GPIO_W = 8;
  localparam int APB_DW = 32;
  localparam int APB_AW = 32;
  localparam int NLANES = APB_DW / 8;

  // Register select is PADDR[2]
  localparam logic CTRL_SEL = 1'b0;
  localparam logic DATA_SEL = 1'b1;

  localparam logic [GPIO_W-1:0] CTRL_RST = '0;
  localparam logic [GPIO_W-1:0] DATA_RST = '0;
endpackage

// File: rtl/gpio_lane_sel.sv
// Picks one write byte from the APB data bus: the lowest lane whose strobe
// is set supplies the byte; lane_hit is low when no strobe is set.
module gpio_lane_sel
  import gpio_apb_port_pkg::*;
(
  input  logic [NLANES-1:0] pstrb,
  input  logic [APB_DW-1:0] pwdata,
  output logic [GPIO_W-1:0] lane_byte,
  output logic              lane_hit
);

  always_comb begin
    lane_byte = '0;
    lane_hit  = 1'b0;
    // Scan high to low so the lowest set strobe is the last assignment
    for (int k = NLANES - 1; k >= 0; k--) begin
      if (pstrb[k]) begin
        lane_byte = pwdata[8*k +: 8];
        lane_hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_apb_port.sv
// 8-bit GPIO port on a zero-wait-state APB slave: CONTROL (direction) and
// DATA registers, masked output pins, masked input readback.
module gpio_apb_port
  import gpio_apb_port_pkg::*;
(
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic [APB_AW-1:0] PADDR,
  input  logic              PWRITE,
  input  logic [NLANES-1:0] PSTRB,
  input  logic [APB_DW-1:0] PWDATA,
  output logic [APB_DW-1:0] PRDATA,
  output logic              PREADY,
  input  logic [GPIO_W-1:0] GPIO_DATA_IN,
  output logic [GPIO_W-1:0] GPIO_DATA_OUT
);

  // Handshake: a transfer completes in every cycle with PSEL & PENABLE high,
  // since PREADY is tied high; a held access phase repeats the transfer.
  logic [GPIO_W-1:0] ctrl_q;
  logic [GPIO_W-1:0] data_q;
  logic [GPIO_W-1:0] wr_byte;
  logic              wr_hit;
  logic              access;
  logic              wr_en;
  logic              reg_sel;
  logic              unused_paddr;

  assign unused_paddr = ^{PADDR[APB_AW-1:3], PADDR[1:0]};

  assign access  = PSEL & PENABLE;
  assign reg_sel = PADDR[2];
  assign wr_en   = access & PWRITE & wr_hit;
  assign PREADY  = 1'b1;

  gpio_lane_sel u_lane_sel (
    .pstrb     (PSTRB),
    .pwdata    (PWDATA),
    .lane_byte (wr_byte),
    .lane_hit  (wr_hit)
  );

  // PRESETn is active-high here; reset takes priority over any write
  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      ctrl_q <= CTRL_RST;
      data_q <= DATA_RST;
    end else if (wr_en) begin
      if (reg_sel == DATA_SEL) data_q <= wr_byte;
      else                     ctrl_q <= wr_byte;
    end
  end

  assign GPIO_DATA_OUT = data_q & ctrl_q;

  always_comb begin
    PRDATA = '0;
    if (access && !PWRITE) begin
      if (reg_sel == CTRL_SEL)
        PRDATA = {{(APB_DW-GPIO_W){1'b0}}, ctrl_q};
      else
        PRDATA = {{(APB_DW-GPIO_W){1'b0}}, GPIO_DATA_IN & ~ctrl_q};
    end
  end

endmodule

// File: tb/tb_gpio_apb_port.sv
// Directed bench for gpio_apb_port: a vector table of APB transfers plus
// hand-written sequences for idle/partial strobes and reset mid-transfer.
module tb_gpio_apb_port;

  logic        PCLK;
  logic        PRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [3:0]  PSTRB;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic [7:0]  GPIO_DATA_IN;
  logic [7:0]  GPIO_DATA_OUT;

  int n_cmp;
  int n_err;

  gpio_apb_port dut (
    .PCLK          (PCLK),
    .PRESETn       (PRESETn),
    .PSEL          (PSEL),
    .PENABLE       (PENABLE),
    .PADDR         (PADDR),
    .PWRITE        (PWRITE),
    .PSTRB         (PSTRB),
    .PWDATA        (PWDATA),
    .PRDATA        (PRDATA),
    .PREADY        (PREADY),
    .GPIO_DATA_IN  (GPIO_DATA_IN),
    .GPIO_DATA_OUT (GPIO_DATA_OUT)
  );

  // Clock and reset defaults
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] paddr;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic [7:0]  gpio_in;
    logic [31:0] exp_prdata;  // during access phase
    logic [7:0]  exp_out;     // after the transfer
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PSTRB   = 4'h0;
    PWDATA  = 32'h0;
    PADDR   = 32'h0;
  endtask

  // One full setup + access transfer; checks PRDATA/PREADY in access phase
  // and the output pins once the transfer has retired.
  task automatic apb_xfer(input string name, input logic [31:0] addr, input logic wr,
                          input logic [3:0] strb, input logic [31:0] wdata,
                          input logic [7:0] gin, input logic [31:0] exp_prd,
                          input logic [7:0] exp_out);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr;
    PSTRB = strb; PWDATA = wdata; GPIO_DATA_IN = gin;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    check({name, " prdata"}, PRDATA, exp_prd);
    check({name, " pready"}, {31'b0, PREADY}, 32'h1);
    @(posedge PCLK); #1;
    idle_bus();
    #1;
    check({name, " out"}, {24'b0, GPIO_DATA_OUT}, {24'b0, exp_out});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle_bus();
    GPIO_DATA_IN = 8'h00;
    PRESETn = 1'b1;

    //          addr          wr    strb     wdata         in     prdata        out
    vecs[0]  = '{32'h0000_0000, 1'b1, 4'b0001, 32'hAF78_CF55, 8'h00, 32'h0,         8'h00};
    vecs[1]  = '{32'hFFFF_FFFF, 1'b1, 4'b0001, 32'hCCAA_FF44, 8'h00, 32'h0,         8'h44};
    vecs[2]  = '{32'hFFFF_FFFF, 1'b0, 4'b0000, 32'h0,         8'h5F, 32'h0000_000A, 8'h44};
    vecs[3]  = '{32'h0000_0000, 1'b0, 4'b0000, 32'h0,         8'h5F, 32'h0000_0055, 8'h44};
    vecs[4]  = '{32'h0000_0000, 1'b1, 4'b0010, 32'hAF78_88CF, 8'h00, 32'h0,         8'h00};
    vecs[5]  = '{32'h0000_0004, 1'b1, 4'b0010, 32'hCCAA_85FF, 8'h00, 32'h0,         8'h80};
    vecs[6]  = '{32'h0000_0004, 1'b1, 4'b0000, 32'h1234_5678, 8'h00, 32'h0,         8'h80};
    vecs[7]  = '{32'h0000_0000, 1'b0, 4'b0000, 32'h0,         8'h00, 32'h0000_0088, 8'h80};
    vecs[8]  = '{32'h0000_0000, 1'b1, 4'b1100, 32'h11FF_2233, 8'h00, 32'h0,         8'h85};
    vecs[9]  = '{32'h0000_0004, 1'b0, 4'b0000, 32'h0,         8'h5F, 32'h0,         8'h85};
    vecs[10] = '{32'h0000_0004, 1'b1, 4'b1000, 32'hA500_0000, 8'h00, 32'h0,         8'hA5};
    vecs[11] = '{32'h0000_0000, 1'b1, 4'b0100, 32'h000F_0000, 8'h00, 32'h0,         8'h05};
    vecs[12] = '{32'h0000_0004, 1'b0, 4'b0000, 32'h0,         8'h3C, 32'h0000_0030, 8'h05};
    vecs[13] = '{32'h0000_0008, 1'b1, 4'b0001, 32'h0000_00F0, 8'h00, 32'h0,         8'hA0};

    // Reset held for two cycles
    repeat (2) @(posedge PCLK);
    #1;
    check("reset out", {24'b0, GPIO_DATA_OUT}, 32'h0);
    check("reset prdata", PRDATA, 32'h0);
    check("reset pready", {31'b0, PREADY}, 32'h1);
    PRESETn = 1'b0;

    for (int i = 0; i < 14; i++) begin
      apb_xfer($sformatf("vec%0d", i), vecs[i].paddr, vecs[i].pwrite, vecs[i].pstrb,
               vecs[i].pwdata, vecs[i].gpio_in, vecs[i].exp_prdata, vecs[i].exp_out);
    end
    // State now: CONTROL=F0, DATA=A5

    // Write with PSEL low is ignored
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h4;
    PSTRB = 4'b0001; PWDATA = 32'h0000_0000;
    @(posedge PCLK); #1;
    check("psel0 write out", {24'b0, GPIO_DATA_OUT}, 32'h0000_00A0);
    // Read without select or in setup phase returns zero
    PWRITE = 1'b0; GPIO_DATA_IN = 8'hFF;
    #1;
    check("psel0 read prdata", PRDATA, 32'h0);
    PSEL = 1'b1; PENABLE = 1'b0;
    #1;
    check("setup read prdata", PRDATA, 32'h0);
    idle_bus();

    // Held write repeats each cycle, then reset arrives mid-transfer
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'h4;
    PSTRB = 4'b0001; PWDATA = 32'h0000_005A;
    repeat (2) @(posedge PCLK);
    #1;
    check("held write out", {24'b0, GPIO_DATA_OUT}, 32'h0000_0050);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    check("reset mid write out", {24'b0, GPIO_DATA_OUT}, 32'h0);
    PRESETn = 1'b0;
    idle_bus();

    // CONTROL and DATA must both be cleared: open all pins, DATA stays 00
    apb_xfer("post reset ctrl", 32'h0, 1'b1, 4'b0001, 32'h0000_00FF, 8'h00, 32'h0, 8'h00);
    apb_xfer("post reset rd ctrl", 32'h0, 1'b0, 4'b0000, 32'h0, 8'h00, 32'h0000_00FF, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
